// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side byte queue.
// Used by the interface, the FIFO core and the drain FSM.
package uart_pkg;

   localparam int UART_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer and UART-facing signals of uart_tx_fifo.
// The slave modport is the FIFO; the master modport is the producer plus the UART.
interface uart_tx_fifo_if #(parameter int AW = 4);
   import uart_pkg::*;

   logic [UART_W-1:0] wr_data;
   logic              wr_en;
   logic              full;
   logic              afull;
   logic              empty;
   logic [AW:0]       count;
   logic              overflow;
   logic [UART_W-1:0] uart_din;
   logic              uart_send;
   logic              uart_txbusy;

   modport master (
      output wr_data, wr_en, uart_txbusy,
      input  full, afull, empty, count, overflow, uart_din, uart_send
   );

   modport slave (
      input  wr_data, wr_en, uart_txbusy,
      output full, afull, empty, count, overflow, uart_din, uart_send
   );

endinterface

// File: rtl/uart_tx_fifo_fifo_sync.sv
// Synchronous circular-buffer FIFO with a dedicated occupancy counter.
// Writes are dropped when full even if a pop happens in the same cycle.
module fifo_sync #(
   parameter int AW = 4,
   parameter int W  = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic [AW:0]  count,
   output logic         full,
   output logic         empty
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   logic [W-1:0]  mem [0:(1<<AW)-1];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == DEPTH);
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop_ok)  rptr <= rptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= din;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue feeding a UART transmitter via its din/send/txbusy handshake.
// Adds the drain FSM, almost-full/overflow flags and the held uart_din byte.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int AW         = 4,
   parameter int AlmostFull = 12
) (
   input  logic           clk,
   input  logic           reset,
   uart_tx_fifo_if.slave  bus
);

   localparam logic [AW:0] AFULL_LVL = (AW+1)'(AlmostFull);

   tx_state_t         state;
   tx_state_t         state_nx;
   logic              pop;
   logic [UART_W-1:0] head;

   fifo_sync #(.AW(AW), .W(UART_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.wr_en),
      .din   (bus.wr_data),
      .pop   (pop),
      .dout  (head),
      .count (bus.count),
      .full  (bus.full),
      .empty (bus.empty)
   );

   assign bus.afull     = (bus.count >= AFULL_LVL);
   assign bus.uart_send = (state == SEND);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      case (state)
         IDLE: begin
            if (!bus.empty && !bus.uart_txbusy) begin
               pop      = 1'b1;
               state_nx = SEND;
            end
         end
         SEND:    if (bus.uart_txbusy)  state_nx = WAIT;
         WAIT:    if (!bus.uart_txbusy) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // uart_din only moves on a pop, so it is stable through SEND and WAIT.
   always_ff @(posedge clk) begin
      if (reset)    bus.uart_din <= '0;
      else if (pop) bus.uart_din <= head;
   end

   always_ff @(posedge clk) begin
      if (reset)                         bus.overflow <= 1'b0;
      else if (bus.wr_en && bus.full)    bus.overflow <= 1'b1;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scenario bench for uart_tx_fifo with a behavioural UART responder and
// a byte-order reference queue.
module tb_uart_tx_fifo;

   logic clk;
   logic reset;

   uart_tx_fifo_if #(.AW(4)) bus ();

   uart_tx_fifo #(.AW(4), .AlmostFull(12)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   // UART responder settings
   int mstate       = 0;
   int cnt          = 0;
   int accept_delay = 0;
   int busy_len     = 4;
   bit hold_busy    = 0;
   bit rand_busy    = 0;

   logic [7:0] rx_q  [$];
   logic [7:0] exp_q [$];

   function automatic int pick_busy();
      if (rand_busy) return int'($urandom_range(20, 3));
      return busy_len;
   endfunction

   // Behavioural UART: captures din on send, raises txbusy after accept_delay,
   // keeps it high for the busy time, then drops it.
   initial begin
      bus.uart_txbusy = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            mstate = 0;
            bus.uart_txbusy = 1'b0;
         end else begin
            case (mstate)
               0: begin
                  bus.uart_txbusy = hold_busy;
                  if (!hold_busy && bus.uart_send) begin
                     rx_q.push_back(bus.uart_din);
                     if (accept_delay == 0) begin
                        bus.uart_txbusy = 1'b1;
                        cnt = pick_busy();
                        mstate = 2;
                     end else begin
                        cnt = accept_delay;
                        mstate = 1;
                     end
                  end
               end
               1: begin
                  cnt--;
                  if (cnt == 0) begin
                     bus.uart_txbusy = 1'b1;
                     cnt = pick_busy();
                     mstate = 2;
                  end
               end
               default: begin
                  cnt--;
                  if (cnt == 0) begin
                     bus.uart_txbusy = 1'b0;
                     mstate = 0;
                  end
               end
            endcase
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.wr_en = 1'b0;
      bus.wr_data = '0;
      hold_busy = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic wait_send(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (bus.uart_send) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_drained(input int n, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (rx_q.size() >= n && bus.empty && !bus.uart_send &&
             mstate == 0 && !bus.uart_txbusy) begin
            ok = 1;
            break;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.wr_en = 1'b0;
      bus.wr_data = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.full, bus.afull, bus.empty, bus.overflow, bus.uart_send} !== 5'b00100) begin
         errors++;
         $display("FAIL reset_flags got %b exp 00100", {bus.full, bus.afull, bus.empty, bus.overflow, bus.uart_send});
      end
      checks++;
      if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
      checks++;
      if (bus.uart_din !== 8'h00) begin errors++; $display("FAIL reset_din got %h exp 00", bus.uart_din); end
   endtask

   task automatic test_single();
      bit ok;
      do_reset();
      accept_delay = 3;
      busy_len = 5;
      rand_busy = 0;
      @(negedge clk);
      bus.wr_en = 1'b1;
      bus.wr_data = 8'hA5;
      @(negedge clk);
      bus.wr_en = 1'b0;
      checks++;
      if (bus.count !== 5'd1 || bus.uart_send !== 1'b0) begin
         errors++;
         $display("FAIL single_after_write count %0d send %b exp 1 0", bus.count, bus.uart_send);
      end
      @(negedge clk);
      checks++;
      if (bus.uart_send !== 1'b1 || bus.uart_din !== 8'hA5 || bus.count !== 5'd0) begin
         errors++;
         $display("FAIL single_latency send %b din %h count %0d exp 1 a5 0", bus.uart_send, bus.uart_din, bus.count);
      end
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (bus.uart_send !== 1'b1) begin errors++; $display("FAIL single_hold send %b exp 1", bus.uart_send); end
      end
      wait_drained(1, 100, ok);
      checks++;
      if (!ok || rx_q.size() != 1 || rx_q[0] !== 8'hA5 || bus.count !== 5'd0) begin
         errors++;
         $display("FAIL single_drain ok %0d rx %0d count %0d exp 1 1 0", ok, rx_q.size(), bus.count);
      end
   endtask

   task automatic test_burst();
      bit ok;
      int bad;
      do_reset();
      accept_delay = 0;
      busy_len = 100;
      rand_busy = 0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         bus.wr_en = 1'b1;
         bus.wr_data = 8'(i);
         exp_q.push_back(8'(i));
      end
      @(negedge clk);
      bus.wr_en = 1'b0;
      checks++;
      if (bus.count > 5'd16 || bus.count < 5'd15 || bus.full !== (bus.count == 5'd16)) begin
         errors++;
         $display("FAIL burst_level count %0d full %b exp 15..16", bus.count, bus.full);
      end
      wait_drained(16, 16 * 110 + 50, ok);
      bad = 0;
      for (int i = 0; i < 16; i++) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
      checks++;
      if (!ok || bad != 0 || rx_q.size() != 16) begin
         errors++;
         $display("FAIL burst_order ok %0d bad %0d rx %0d exp 1 0 16", ok, bad, rx_q.size());
      end
      checks++;
      if (bus.overflow !== 1'b0) begin errors++; $display("FAIL burst_overflow got %b exp 0", bus.overflow); end
   endtask

   task automatic test_wrap();
      bit ok;
      int bad;
      do_reset();
      accept_delay = 0;
      rand_busy = 1;
      for (int b = 0; b < 4; b++) begin
         for (int j = 0; j < 10; j++) begin
            logic [7:0] v;
            v = 8'($urandom);
            @(negedge clk);
            bus.wr_en = 1'b1;
            bus.wr_data = v;
            exp_q.push_back(v);
         end
         @(negedge clk);
         bus.wr_en = 1'b0;
         wait_drained(10 * (b + 1), 600, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL wrap_drain burst %0d rx %0d exp %0d", b, rx_q.size(), 10 * (b + 1)); end
      end
      bad = 0;
      for (int i = 0; i < 40; i++) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
      checks++;
      if (bad != 0 || rx_q.size() != 40) begin
         errors++;
         $display("FAIL wrap_order bad %0d rx %0d exp 0 40", bad, rx_q.size());
      end
      checks++;
      if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", bus.empty); end
      rand_busy = 0;
   endtask

   task automatic test_slow_accept();
      bit ok;
      int bad;
      do_reset();
      accept_delay = 37;
      busy_len = 6;
      rand_busy = 0;
      @(negedge clk);
      bus.wr_en = 1'b1;
      bus.wr_data = 8'h5A;
      @(negedge clk);
      bus.wr_data = 8'hC3;
      @(negedge clk);
      bus.wr_en = 1'b0;
      wait_send(20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL slow_send_timeout send %b exp 1", bus.uart_send); end
      bad = 0;
      for (int i = 0; i < 37; i++) begin
         if (bus.uart_send !== 1'b1 || bus.uart_din !== 8'h5A || bus.count !== 5'd1) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL slow_hold bad_cycles %0d exp 0", bad); end
      accept_delay = 0;
      wait_drained(2, 200, ok);
      checks++;
      if (!ok || rx_q.size() != 2 || rx_q[0] !== 8'h5A || rx_q[1] !== 8'hC3) begin
         errors++;
         $display("FAIL slow_order ok %0d rx %0d exp 1 2", ok, rx_q.size());
      end
   endtask

   task automatic test_overflow();
      bit ok;
      int bad;
      do_reset();
      accept_delay = 0;
      busy_len = 4;
      rand_busy = 0;
      hold_busy = 1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         if (i == 11) begin
            checks++;
            if (bus.afull !== 1'b0) begin errors++; $display("FAIL afull_below got %b exp 0", bus.afull); end
         end
         if (i == 12) begin
            checks++;
            if (bus.afull !== 1'b1) begin errors++; $display("FAIL afull_at got %b exp 1", bus.afull); end
         end
         if (i == 16) begin
            checks++;
            if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
               errors++;
               $display("FAIL full_edge full %b ovf %b exp 1 0", bus.full, bus.overflow);
            end
         end
         bus.wr_en = 1'b1;
         bus.wr_data = 8'h20 + 8'(i);
         if (i < 16) exp_q.push_back(8'h20 + 8'(i));
      end
      @(negedge clk);
      bus.wr_en = 1'b0;
      checks++;
      if (bus.count !== 5'd16 || {bus.full, bus.afull, bus.overflow} !== 3'b111) begin
         errors++;
         $display("FAIL overflow_flags count %0d f/af/ovf %b exp 16 111", bus.count, {bus.full, bus.afull, bus.overflow});
      end
      hold_busy = 0;
      wait_drained(16, 16 * 20 + 50, ok);
      repeat (20) @(negedge clk);
      bad = 0;
      for (int i = 0; i < 16; i++) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
      checks++;
      if (!ok || bad != 0 || rx_q.size() != 16) begin
         errors++;
         $display("FAIL overflow_order ok %0d bad %0d rx %0d exp 1 0 16", ok, bad, rx_q.size());
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      accept_delay = 200;
      busy_len = 4;
      rand_busy = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.wr_en = 1'b1;
         bus.wr_data = 8'h40 + 8'(i);
      end
      @(negedge clk);
      bus.wr_en = 1'b0;
      wait_send(20, ok);
      @(negedge clk);
      checks++;
      if (!ok || bus.count !== 5'd5 || bus.uart_send !== 1'b1 || bus.overflow !== 1'b1) begin
         errors++;
         $display("FAIL midreset_pre ok %0d count %0d send %b ovf %b exp 1 5 1 1", ok, bus.count, bus.uart_send, bus.overflow);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.uart_send !== 1'b0 || bus.count !== 5'd0 || bus.empty !== 1'b1 ||
          bus.overflow !== 1'b0 || bus.uart_din !== 8'h00) begin
         errors++;
         $display("FAIL midreset_state send %b count %0d empty %b ovf %b din %h exp 0 0 1 0 00",
                  bus.uart_send, bus.count, bus.empty, bus.overflow, bus.uart_din);
      end
      reset = 1'b0;
      accept_delay = 0;
      @(negedge clk);
      rx_q.delete();
      bus.wr_en = 1'b1;
      bus.wr_data = 8'h3C;
      @(negedge clk);
      bus.wr_en = 1'b0;
      wait_drained(1, 100, ok);
      checks++;
      if (!ok || rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
         errors++;
         $display("FAIL midreset_resume ok %0d rx %0d exp 1 1 (byte 3c)", ok, rx_q.size());
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.wr_en = 1'b0;
      bus.wr_data = '0;
      test_reset();
      test_single();
      test_burst();
      test_wrap();
      test_slow_accept();
      test_overflow();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
